cpu_sram_bridge: RTL and testbench

Sits directly downstream of the CPU core. Converts the core's two fixed-latency SRAM ports (instruction and data) into one shared sram-like bus with address/data handshakes. Serialises simultaneous requests with data-side priority, holds returned read data in registers, and raises `stallreq` back to the core's stall controller while any accepted request is outstanding.

---
 rtl/cpu_sram_bridge_pkg.sv | 27 ++
 rtl/cpu_sram_bridge_addr_map.sv | 18 +
 rtl/cpu_sram_bridge.sv | 142 ++++++++++++++
 tb/tb_cpu_sram_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sram_bridge_pkg.sv
// Shared constants and types for the CPU-to-SRAM-like bus bridge.
// Holds the bus widths, the bridge FSM encoding and the kseg0/kseg1
// window constants used by the optional address map
// (CPU_SRAM_BRIDGE_KSEG_MAP_EN).
package cpu_sram_bridge_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // kseg0/kseg1 occupy 0x8000_0000-0xBFFF_FFFF: top two bits are 2'b10.
  localparam logic [ADDR_W-1:0] KSEG_BASE     = 32'h8000_0000;
  localparam logic [ADDR_W-1:0] KSEG_SEL_MASK = 32'hC000_0000;
  // Clearing bits [31:29] folds both segments onto physical memory.
  localparam logic [ADDR_W-1:0] KSEG_CLR_MASK = 32'h1FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } bridge_state_t;

  function automatic logic is_kseg01(input logic [ADDR_W-1:0] addr);
    return (addr & KSEG_SEL_MASK) == KSEG_BASE;
  endfunction

endpackage

// File: rtl/cpu_sram_bridge_addr_map.sv
// Combinational core-to-bus address translator.
// With CPU_SRAM_BRIDGE_KSEG_MAP_EN defined, kseg0/kseg1 addresses have
// bits [31:29] cleared; every other address passes through unchanged.
// Without the macro the address is forwarded untouched.
module cpu_addr_map
  import cpu_sram_bridge_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] mapped
);

`ifdef CPU_SRAM_BRIDGE_KSEG_MAP_EN
  assign mapped = is_kseg01(addr) ? (addr & KSEG_CLR_MASK) : addr;
`else
  assign mapped = addr;
`endif

endmodule

// File: rtl/cpu_sram_bridge.sv
// Bridge from the core's fixed-latency instruction and data SRAM ports
// onto one shared sram-like bus (addr_ok / data_ok handshakes).
// Requests are captured into pending registers, served one at a time
// with data-side priority, and stallreq holds the core while busy.
// Optional macro: CPU_SRAM_BRIDGE_KSEG_MAP_EN (kseg0/kseg1 address map).
//
// Handshake: the bridge holds bus_req and all request fields stable from
// the cycle it raises bus_req until an edge where bus_addr_ok is high;
// that edge transfers the request. Exactly one bus_data_ok edge later
// completes it (read data valid on bus_rdata on that edge).
module cpu_sram_bridge
  import cpu_sram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_sram_en,
  input  logic [STRB_W-1:0] inst_sram_wen,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,
  input  logic              data_sram_en,
  input  logic [STRB_W-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  output logic              stallreq,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  bridge_state_t     state;
  bridge_state_t     state_nxt;

  logic              d_pend;
  logic [ADDR_W-1:0] d_addr;
  logic [STRB_W-1:0] d_wen;
  logic [DATA_W-1:0] d_wdata;
  logic              i_pend;
  logic [ADDR_W-1:0] i_addr;
  logic [ADDR_W-1:0] req_addr;

  // Instruction requests are always reads, so their strobes/data are dropped.
  logic unused_inst_fields;
  assign unused_inst_fields = ^{inst_sram_wen, inst_sram_wdata};

  // While d_pend is set the data request is the one being served;
  // it is only cleared once its own data_ok arrives.
  logic serve_data;
  assign serve_data = d_pend;

  logic resp_done;
  assign resp_done = (state == ST_DATA) && bus_data_ok;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (data_sram_en || inst_sram_en) state_nxt = ST_ADDR;
      ST_ADDR: if (bus_addr_ok)                  state_nxt = ST_DATA;
      ST_DATA: if (bus_data_ok)                  state_nxt = (d_pend && i_pend) ? ST_ADDR : ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: bus fields are driven only in ADDR and zero otherwise.
  always_comb begin
    stallreq  = (state != ST_IDLE);
    bus_req   = 1'b0;
    bus_wr    = 1'b0;
    bus_wstrb = '0;
    bus_wdata = '0;
    req_addr  = '0;
    if (state == ST_ADDR) begin
      bus_req = 1'b1;
      if (serve_data) begin
        bus_wr    = |d_wen;
        bus_wstrb = d_wen;
        bus_wdata = d_wdata;
        req_addr  = d_addr;
      end else begin
        req_addr  = i_addr;
      end
    end
  end

  cpu_addr_map u_addr_map (
    .addr   (req_addr),
    .mapped (bus_addr)
  );

  // Pending capture in IDLE (core enables are only looked at there) and
  // retirement of the served request on its data_ok.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_pend  <= 1'b0;
      d_addr  <= '0;
      d_wen   <= '0;
      d_wdata <= '0;
      i_pend  <= 1'b0;
      i_addr  <= '0;
    end else if (state == ST_IDLE) begin
      d_pend <= data_sram_en;
      i_pend <= inst_sram_en;
      if (data_sram_en) begin
        d_addr  <= data_sram_addr;
        d_wen   <= data_sram_wen;
        d_wdata <= data_sram_wdata;
      end
      if (inst_sram_en) i_addr <= inst_sram_addr;
    end else if (resp_done) begin
      if (serve_data) d_pend <= 1'b0;
      else            i_pend <= 1'b0;
    end
  end

  // Read-data holding registers; writes leave them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_sram_rdata <= '0;
      data_sram_rdata <= '0;
    end else if (resp_done) begin
      if (serve_data) begin
        if (d_wen == '0) data_sram_rdata <= bus_rdata;
      end else begin
        inst_sram_rdata <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Directed bench for cpu_sram_bridge: a table of request vectors served
// by a simple bus slave, plus hand-written reset-in-flight sequence.
module tb_cpu_sram_bridge;

  logic        clk;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  cpu_sram_bridge dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stallreq        (stallreq),
    .bus_req         (bus_req),
    .bus_wr          (bus_wr),
    .bus_wstrb       (bus_wstrb),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_addr_ok     (bus_addr_ok),
    .bus_data_ok     (bus_data_ok),
    .bus_rdata       (bus_rdata)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected bus transactions: {wr, wstrb[3:0], addr[31:0], wdata[31:0], resp[31:0]}
  logic [100:0] exp_q[$];

  typedef struct {
    logic        d_en;
    logic [3:0]  d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        i_en;
    logic [31:0] i_addr;
    logic [31:0] d_resp;
    logic [31:0] i_resp;
    int          wait_cyc;
    logic        hold_en;
    int          exp_done;
    logic [31:0] exp_i;
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_map(input logic [31:0] a);
`ifdef CPU_SRAM_BRIDGE_KSEG_MAP_EN
    if (a[31:30] == 2'b10) return {3'b000, a[28:0]};
`endif
    return a;
  endfunction

  task automatic drop_enables();
    data_sram_en  = 1'b0;
    inst_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
  endtask

  // Driver + slave: presents one vector at cycle 0, then acts as the bus
  // slave (addr_ok after wait_cyc stalled cycles, data_ok one cycle later).
  task automatic run_vec(input vec_t v, input string nm);
    int          cyc;
    int          waits;
    logic        acc;
    logic        done;
    logic [31:0] cur_resp;
    logic [100:0] e;
    if (v.d_en) exp_q.push_back({|v.d_wen, v.d_wen, exp_map(v.d_addr), v.d_wdata, v.d_resp});
    if (v.i_en) exp_q.push_back({1'b0, 4'h0, exp_map(v.i_addr), 32'h0, v.i_resp});
    data_sram_en    = v.d_en;
    data_sram_wen   = v.d_wen;
    data_sram_addr  = v.d_addr;
    data_sram_wdata = v.d_wdata;
    inst_sram_en    = v.i_en;
    inst_sram_addr  = v.i_addr;
    @(posedge clk); #1;
    cyc = 1; waits = v.wait_cyc; acc = 1'b0; done = 1'b0; cur_resp = 32'h0;
    if (!v.hold_en) drop_enables();
    while (!done && cyc <= 20) begin
      bus_data_ok = acc;
      bus_rdata   = acc ? cur_resp : 32'h0;
      acc = 1'b0;
      if (!stallreq) begin
        done = 1'b1;
        drop_enables();
        bus_addr_ok = 1'b0;
      end else begin
        if (bus_req) begin
          if (exp_q.size() == 0) begin
            check({nm, " unexpected bus_req"}, 128'(bus_req), 128'(0));
            bus_addr_ok = 1'b1;
          end else begin
            e = exp_q[0];
            check({nm, " bus fields"}, {bus_wr, bus_wstrb, bus_addr, bus_wdata}, e[100:32]);
            if (waits > 0) begin
              bus_addr_ok = 1'b0;
              waits--;
            end else begin
              bus_addr_ok = 1'b1;
              acc = 1'b1;
              cur_resp = e[31:0];
              void'(exp_q.pop_front());
            end
          end
        end else begin
          bus_addr_ok = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    bus_addr_ok = 1'b0;
    drop_enables();
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: stallreq still %0b after %0d cycles, required 0", nm, stallreq, cyc);
    end else begin
      check({nm, " done cycle"}, 128'(cyc), 128'(v.exp_done));
    end
    check({nm, " inst_rdata"}, 128'(inst_sram_rdata), 128'(v.exp_i));
    check({nm, " data_rdata"}, 128'(data_sram_rdata), 128'(v.exp_d));
    check({nm, " txn left"}, 128'(exp_q.size()), 128'(0));
    exp_q.delete();
    // No further transaction may appear once the request retired.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check({nm, " idle after"}, {bus_req, stallreq}, 2'b00);
    end
  endtask

  initial begin
    // d_en wen    d_addr        d_wdata       i_en i_addr        d_resp        i_resp        wait hold done exp_i         exp_d
    vecs[0] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 32'h8000_0100, 32'h0,         32'h2408_0001, 0, 1'b0, 3, 32'h2408_0001, 32'h0};
    vecs[1] = '{1'b1, 4'h0, 32'h0000_2000, 32'h0,         1'b0, 32'h0,         32'h1122_3344, 32'h0,         0, 1'b0, 3, 32'h2408_0001, 32'h1122_3344};
    vecs[2] = '{1'b1, 4'h3, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 32'h8000_0104, 32'hFFFF_FFFF, 32'h3C01_BFC0, 0, 1'b0, 5, 32'h3C01_BFC0, 32'h1122_3344};
    vecs[3] = '{1'b1, 4'h0, 32'hA000_0040, 32'h0,         1'b1, 32'h0040_0000, 32'h0BAD_F00D, 32'h1234_5678, 0, 1'b0, 5, 32'h1234_5678, 32'h0BAD_F00D};
    vecs[4] = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b1, 32'h0040_0004, 32'h0,         32'h8765_4321, 3, 1'b0, 6, 32'h8765_4321, 32'h0BAD_F00D};
    vecs[5] = '{1'b1, 4'hF, 32'hBFC0_0000, 32'hCAFE_0001, 1'b0, 32'h0,         32'hFFFF_FFFF, 32'h0,         3, 1'b0, 6, 32'h8765_4321, 32'h0BAD_F00D};
    vecs[6] = '{1'b1, 4'h0, 32'hC000_0000, 32'h0,         1'b0, 32'h0,         32'h5555_AAAA, 32'h0,         0, 1'b0, 3, 32'h8765_4321, 32'h5555_AAAA};
    vecs[7] = '{1'b1, 4'h0, 32'h0000_3000, 32'h0,         1'b1, 32'h0000_3004, 32'h0F0F_0F0F, 32'h7777_8888, 0, 1'b1, 5, 32'h7777_8888, 32'h0F0F_0F0F};

    rst             = 1'b0;
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'hF;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'hFFFF_FFFF;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    bus_addr_ok     = 1'b0;
    bus_data_ok     = 1'b0;
    bus_rdata       = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {stallreq, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata}, 70'h0);
    check("reset rdata", {inst_sram_rdata, data_sram_rdata}, 64'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset asserted while a read sits in DATA; the late data_ok is stray.
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'h8000_0200;
    @(posedge clk); #1;
    drop_enables();
    check("rst_seq bus_req", 128'(bus_req), 128'(1));
    check("rst_seq addr", 128'(bus_addr), 128'(exp_map(32'h8000_0200)));
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    check("rst_seq in data", {stallreq, bus_req}, 2'b10);
    rst = 1'b0;
    #1;
    check("rst_seq async outputs", {stallreq, bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata}, 70'h0);
    check("rst_seq rdata cleared", {inst_sram_rdata, data_sram_rdata}, 64'h0);
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    bus_rdata   = 32'h0;
    check("rst_seq stray ignored", {stallreq, bus_req}, 2'b00);
    check("rst_seq rdata stays 0", {inst_sram_rdata, data_sram_rdata}, 64'h0);
    @(posedge clk); #1;
    check("rst_seq still idle", {stallreq, bus_req}, 2'b00);

    run_vec('{1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0000_0010, 32'h0, 32'h0000_0001,
              0, 1'b0, 3, 32'h0000_0001, 32'h0}, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
